// File: rtl/conv2_sched_if.sv
// Handshake and control bundle between the conv2 scheduler and its operand
// buffers, filter datapath and downstream result sink.
interface conv2_sched_if #(
  parameter int RW = 4,
  parameter int CW = 4,
  parameter int FW = 4
);
  logic          start;
  logic [1:0]    mode;
  logic          busy;
  logic          done;
  logic          fetch_req;
  logic          fetch_ack;
  logic [RW-1:0] win_row;
  logic [CW-1:0] win_col;
  logic [FW-1:0] filt_idx;
  logic          filt_clr;
  logic          filt_we;
  logic [1:0]    sel;
  logic          and_control;
  logic          res_valid;
  logic          res_ready;

  modport master (
    input  start, mode, fetch_ack, res_ready,
    output busy, done, fetch_req, win_row, win_col, filt_idx,
           filt_clr, filt_we, sel, and_control, res_valid
  );

  modport slave (
    output start, mode, fetch_ack, res_ready,
    input  busy, done, fetch_req, win_row, win_col, filt_idx,
           filt_clr, filt_we, sel, and_control, res_valid
  );
endinterface

// File: rtl/conv2_sched.sv
// Sequencer for the conv2 filter datapath: walks every (row, col, filter)
// triple, fetching operands, strobing the datapath and emitting results.
module conv2_sched #(
  parameter int OUT_H  = 8,
  parameter int OUT_W  = 8,
  parameter int N_FILT = 16,
  parameter int RW     = 4,
  parameter int CW     = 4,
  parameter int FW     = 4
) (
  input  logic          CLK,
  input  logic          CLR,
  conv2_sched_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    COMPUTE,
    EMIT,
    DONE
  } state_t;

  localparam logic [RW-1:0] ROW_MAX  = RW'(OUT_H - 1);
  localparam logic [CW-1:0] COL_MAX  = CW'(OUT_W - 1);
  localparam logic [FW-1:0] FILT_MAX = FW'(N_FILT - 1);

  state_t        state;
  state_t        state_nxt;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  logic [FW-1:0] filt;
  logic [1:0]    sel_q;

  logic filt_last;
  logic col_last;
  logic row_last;
  logic triple_last;
  logic start_go;
  logic emit_done;

  logic busy_c;
  logic done_c;
  logic fetch_req_c;
  logic filt_clr_c;
  logic filt_we_c;
  logic and_control_c;
  logic res_valid_c;

  assign filt_last   = (filt == FILT_MAX);
  assign col_last    = (col == COL_MAX);
  assign row_last    = (row == ROW_MAX);
  assign triple_last = filt_last && col_last && row_last;
  assign start_go    = (state == IDLE) && bus.start;
  assign emit_done   = (state == EMIT) && bus.res_ready;

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Moore outputs: every strobe is a pure function of the current state,
  // so a stall simply holds the state and with it every output.
  always_comb begin
    state_nxt     = state;
    busy_c        = 1'b1;
    done_c        = 1'b0;
    fetch_req_c   = 1'b0;
    filt_clr_c    = 1'b0;
    filt_we_c     = 1'b0;
    and_control_c = 1'b0;
    res_valid_c   = 1'b0;
    case (state)
      IDLE: begin
        busy_c = 1'b0;
        if (bus.start) begin
          state_nxt = CLEAR;
        end
      end
      CLEAR: begin
        filt_clr_c = 1'b1;
        state_nxt  = FETCH;
      end
      FETCH: begin
        fetch_req_c = 1'b1;
        if (bus.fetch_ack) begin
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        filt_we_c     = 1'b1;
        and_control_c = 1'b1;
        state_nxt     = EMIT;
      end
      EMIT: begin
        res_valid_c = 1'b1;
        if (bus.res_ready) begin
          state_nxt = triple_last ? DONE : FETCH;
        end
      end
      DONE: begin
        done_c    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        busy_c    = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  // Filter index is innermost; a wrap carries into column, then row.
  // Advancing past the last triple wraps everything back to zero.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      row   <= '0;
      col   <= '0;
      filt  <= '0;
      sel_q <= 2'b00;
    end else if (start_go) begin
      row   <= '0;
      col   <= '0;
      filt  <= '0;
      sel_q <= bus.mode;
    end else if (state == DONE) begin
      row  <= '0;
      col  <= '0;
      filt <= '0;
    end else if (emit_done) begin
      if (filt_last) begin
        filt <= '0;
        if (col_last) begin
          col <= '0;
          if (row_last) begin
            row <= '0;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end else begin
        filt <= filt + 1'b1;
      end
    end
  end

  assign bus.busy        = busy_c;
  assign bus.done        = done_c;
  assign bus.fetch_req   = fetch_req_c;
  assign bus.filt_clr    = filt_clr_c;
  assign bus.filt_we     = filt_we_c;
  assign bus.and_control = and_control_c;
  assign bus.res_valid   = res_valid_c;
  assign bus.sel         = sel_q;
  assign bus.win_row     = row;
  assign bus.win_col     = col;
  assign bus.filt_idx    = filt;

endmodule

// File: tb/tb_conv2_sched.sv
// Self-checking bench for conv2_sched: directed layer runs with random stalls,
// ignored inputs and mode noise, checked against a transaction-level model.
module tb_conv2_sched;

  localparam int OUT_H  = 2;
  localparam int OUT_W  = 2;
  localparam int N_FILT = 2;
  localparam int RW     = 2;
  localparam int CW     = 2;
  localparam int FW     = 2;
  localparam int N_RES  = OUT_H * OUT_W * N_FILT;

  // Flag order: {busy, done, fetch_req, filt_clr, filt_we, and_control, res_valid}
  localparam logic [6:0] F_IDLE  = 7'b0000000;
  localparam logic [6:0] F_CLEAR = 7'b1001000;
  localparam logic [6:0] F_FETCH = 7'b1010000;
  localparam logic [6:0] F_COMP  = 7'b1000110;
  localparam logic [6:0] F_EMIT  = 7'b1000001;
  localparam logic [6:0] F_DONE  = 7'b1100000;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  conv2_sched_if #(.RW(RW), .CW(CW), .FW(FW)) bus ();

  conv2_sched #(
    .OUT_H(OUT_H), .OUT_W(OUT_W), .N_FILT(N_FILT),
    .RW(RW), .CW(CW), .FW(FW)
  ) dut (
    .CLK(clk),
    .CLR(clr),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_phase(input string tag, input logic [6:0] fl,
                             input int er, input int ec, input int ef, input logic [1:0] es);
    logic [31:0] o;
    logic [31:0] e;
    o = 32'({bus.busy, bus.done, bus.fetch_req, bus.filt_clr, bus.filt_we,
             bus.and_control, bus.res_valid, bus.sel, bus.win_row, bus.win_col, bus.filt_idx});
    e = 32'({fl, es, RW'(er), CW'(ec), FW'(ef)});
    checkOutput(tag, o, e);
  endtask

  // One layer run. fs_k/fs_n and rs_k/rs_n force a fetch / ready stall of the
  // given length on one triple; abort_k resets the block during that EMIT.
  task automatic applyStimulus(input logic [1:0] m, input int fs_k, input int fs_n,
                               input int rs_k, input int rs_n, input int max_stall,
                               input int abort_k, input bit noisy);
    int er[$];
    int ec[$];
    int ef[$];
    int cyc;
    int stall;
    int accepted;
    bit timed;
    timed    = !noisy && fs_k < 0 && rs_k < 0;
    accepted = 0;
    for (int i = 0; i < OUT_H; i++)
      for (int j = 0; j < OUT_W; j++)
        for (int k = 0; k < N_FILT; k++) begin
          er.push_back(i);
          ec.push_back(j);
          ef.push_back(k);
        end

    bus.mode  = m;
    bus.start = 1'b1;
    tick();
    cyc = 1;
    bus.start = 1'b0;
    if (noisy) bus.mode = 2'($urandom);
    check_phase("clear", F_CLEAR, 0, 0, 0, m);
    tick();
    cyc++;

    for (int k = 0; k < N_RES; k++) begin
      stall = (k == fs_k) ? fs_n : (noisy ? int'($urandom_range(max_stall, 0)) : 0);
      for (int s = 0; s <= stall; s++) begin
        bus.fetch_ack = (s == stall);
        bus.res_ready = noisy ? 1'($urandom) : 1'b1;
        bus.start     = noisy ? 1'($urandom) : 1'b0;
        if (noisy) bus.mode = 2'($urandom);
        check_phase("fetch", F_FETCH, er[k], ec[k], ef[k], m);
        tick();
        cyc++;
      end
      bus.start     = 1'b0;
      bus.fetch_ack = noisy ? 1'($urandom) : 1'b1;
      check_phase("compute", F_COMP, er[k], ec[k], ef[k], m);
      tick();
      cyc++;
      stall = (k == rs_k) ? rs_n : (noisy ? int'($urandom_range(max_stall, 0)) : 0);
      for (int s = 0; s <= stall; s++) begin
        bus.res_ready = (s == stall);
        bus.fetch_ack = noisy ? 1'($urandom) : 1'b1;
        bus.start     = noisy ? 1'($urandom) : 1'b0;
        check_phase("emit", F_EMIT, er[k], ec[k], ef[k], m);
        if (k == abort_k) begin
          bus.start = 1'b0;
          clr = 1'b1;
          tick();
          clr = 1'b0;
          check_phase("mid_reset", F_IDLE, 0, 0, 0, 2'd0);
          tick();
          check_phase("post_reset_idle", F_IDLE, 0, 0, 0, 2'd0);
          return;
        end
        if (timed && s == stall) checkOutput("valid_cycle", cyc, 4 + 3 * k);
        if (s == stall && bus.res_valid === 1'b1) accepted++;
        tick();
        cyc++;
      end
    end

    // start coinciding with done must be ignored
    bus.start = 1'b1;
    check_phase("done", F_DONE, 0, 0, 0, m);
    if (timed) checkOutput("done_cycle", cyc, 2 + 3 * N_RES);
    checkOutput("result_count", accepted, N_RES);
    tick();
    bus.start = 1'b0;
    check_phase("idle", F_IDLE, 0, 0, 0, m);
    tick();
    check_phase("idle_hold", F_IDLE, 0, 0, 0, m);
  endtask

  initial begin
    clr           = 1'b1;
    bus.start     = 1'b0;
    bus.mode      = 2'd3;
    bus.fetch_ack = 1'b0;
    bus.res_ready = 1'b0;
    tick();
    tick();
    check_phase("reset", F_IDLE, 0, 0, 0, 2'd0);
    clr = 1'b0;
    tick();
    check_phase("reset_release", F_IDLE, 0, 0, 0, 2'd0);

    applyStimulus(2'd2, -1, 0, -1, 0, 0, -1, 1'b0);
    applyStimulus(2'd2, 1, 5, 2, 4, 0, -1, 1'b0);
    applyStimulus(2'd1, -1, 0, -1, 0, 3, -1, 1'b1);
    applyStimulus(2'd3, -1, 0, -1, 0, 0, 2, 1'b0);
    applyStimulus(2'd2, -1, 0, -1, 0, 2, -1, 1'b1);
    for (int i = 0; i < 3; i++)
      applyStimulus(2'($urandom), -1, 0, -1, 0, 3, -1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
